// File: rtl/ex_stage.sv
// Execute stage: ALU decode/op, branch target, dest select, iterative MULT/MULTU with HI/LO.
// Latency: 1 cycle ID/EX -> EX/MEM; multiply holds the stage for 1+MUL_CYCLES cycles, then one DONE bubble.
// Backpressure: stall_ex (combinational) freezes upstream while a multiply is being accepted or iterating.
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_regWrite_id_ex,
  input  logic        ctrl_memToReg_id_ex,
  input  logic        ctrl_branch_id_ex,
  input  logic        ctrl_memRead_id_ex,
  input  logic        ctrl_memWrite_id_ex,
  input  logic        ctrl_regDest_id_ex,
  input  logic        ctrl_aluSrc_id_ex,
  input  logic [1:0]  ctrl_aluOp_id_ex,
  input  logic [31:0] supposed_next_address_id_ex,
  input  logic [31:0] read_data_1_id_ex,
  input  logic [31:0] read_data_2_id_ex,
  input  logic [31:0] extended_branch_offset_id_ex,
  input  logic [4:0]  next_instruction_20_16_id_ex,
  input  logic [4:0]  next_instruction_15_11_id_ex,
  output logic        ctrl_regWrite_ex_mem,
  output logic        ctrl_memToReg_ex_mem,
  output logic        ctrl_branch_ex_mem,
  output logic        ctrl_memRead_ex_mem,
  output logic        ctrl_memWrite_ex_mem,
  output logic [31:0] alu_result_ex_mem,
  output logic        alu_zero_ex_mem,
  output logic [31:0] branch_target_ex_mem,
  output logic [31:0] read_data_2_ex_mem,
  output logic [4:0]  write_reg_ex_mem,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_ex
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Operand and decode signals
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [5:0]  funct;
  logic        is_rtype;
  logic        is_mul;
  logic        is_smul;
  logic [31:0] alu_res;

  // Multiplier state
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic [63:0]      acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [32:0]      add_sum;
  logic [63:0]      acc_step;
  logic [63:0]      prod_fix;
  logic [31:0]      a_mag;
  logic [31:0]      b_mag;
  logic             take_normal;

  // EX/MEM registers
  logic        rw_q, m2r_q, br_q, mr_q, mw_q, zero_q;
  logic [31:0] res_q, bt_q, rd2_q;
  logic [4:0]  wr_q;

  assign op_a     = read_data_1_id_ex;
  assign op_b     = ctrl_aluSrc_id_ex ? extended_branch_offset_id_ex : read_data_2_id_ex;
  assign funct    = extended_branch_offset_id_ex[5:0];
  assign is_rtype = (ctrl_aluOp_id_ex == 2'b10);
  assign is_smul  = is_rtype && (funct == 6'h18);
  assign is_mul   = is_rtype && ((funct == 6'h18) || (funct == 6'h19));

  // ALU: aluOp selects add/sub directly, R-type decodes funct
  always_comb begin
    alu_res = '0;
    case (ctrl_aluOp_id_ex)
      2'b01: alu_res = op_a - op_b;
      2'b10: begin
        case (funct)
          6'h20, 6'h21: alu_res = op_a + op_b;
          6'h22, 6'h23: alu_res = op_a - op_b;
          6'h24:        alu_res = op_a & op_b;
          6'h25:        alu_res = op_a | op_b;
          6'h26:        alu_res = op_a ^ op_b;
          6'h27:        alu_res = ~(op_a | op_b);
          6'h2A:        alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
          6'h2B:        alu_res = {31'd0, (op_a < op_b)};
          6'h10:        alu_res = hi_q;
          6'h12:        alu_res = lo_q;
          default:      alu_res = '0;
        endcase
      end
      default: alu_res = op_a + op_b;
    endcase
  end

  // Shift-add step; the carry out of the upper half becomes the new MSB after the shift
  assign add_sum  = {1'b0, acc_q[63:32]} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign acc_step = 64'({add_sum, acc_q[31:0]} >> 1);
  assign prod_fix = neg_q ? (~acc_step + 64'd1) : acc_step;
  assign a_mag    = (is_smul && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign b_mag    = (is_smul && op_b[31]) ? (~op_b + 32'd1) : op_b;

  // Multiply FSM next-state; normal instructions only flow through in IDLE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    take_normal = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mul) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = is_smul && (op_a[31] ^ op_b[31]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_MUL;
        end else begin
          take_normal = 1'b1;
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          hi_d    = prod_fix[63:32];
          lo_d    = prod_fix[31:0];
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Gated by reset so the hazard unit sees no stall while the stage is held in reset
  assign stall_ex = reset && (((state_q == ST_IDLE) && is_mul) || (state_q == ST_MUL));

  // Multiplier and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // EX/MEM bundle: capture the instruction, or an all-zero bubble while multiplying
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_q   <= 1'b0;
      m2r_q  <= 1'b0;
      br_q   <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b0;
      bt_q   <= '0;
      rd2_q  <= '0;
      wr_q   <= '0;
    end else if (take_normal) begin
      rw_q   <= ctrl_regWrite_id_ex;
      m2r_q  <= ctrl_memToReg_id_ex;
      br_q   <= ctrl_branch_id_ex;
      mr_q   <= ctrl_memRead_id_ex;
      mw_q   <= ctrl_memWrite_id_ex;
      res_q  <= alu_res;
      zero_q <= (alu_res == 32'd0);
      bt_q   <= supposed_next_address_id_ex + {extended_branch_offset_id_ex[29:0], 2'b00};
      rd2_q  <= read_data_2_id_ex;
      wr_q   <= ctrl_regDest_id_ex ? next_instruction_15_11_id_ex : next_instruction_20_16_id_ex;
    end else begin
      rw_q   <= 1'b0;
      m2r_q  <= 1'b0;
      br_q   <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b0;
      bt_q   <= '0;
      rd2_q  <= '0;
      wr_q   <= '0;
    end
  end

  assign ctrl_regWrite_ex_mem = rw_q;
  assign ctrl_memToReg_ex_mem = m2r_q;
  assign ctrl_branch_ex_mem   = br_q;
  assign ctrl_memRead_ex_mem  = mr_q;
  assign ctrl_memWrite_ex_mem = mw_q;
  assign alu_result_ex_mem    = res_q;
  assign alu_zero_ex_mem      = zero_q;
  assign branch_target_ex_mem = bt_q;
  assign read_data_2_ex_mem   = rd2_q;
  assign write_reg_ex_mem     = wr_q;
  assign hi                   = hi_q;
  assign lo                   = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: random instruction stream against a behavioural model, plus literal spot checks.
// Latency: model predicts EX/MEM one edge after issue; multiplies modelled as a 64-bit product after 33 stall cycles.
// Backpressure: the driver holds ID/EX inputs across every edge preceded by stall_ex=1.
module tb_ex_stage;

  localparam int MULC = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        rw_i, m2r_i, br_i, mr_i, mw_i, rdst_i, asrc_i;
  logic [1:0]  aluop_i;
  logic [31:0] pc4_i, a_i, b_i, ext_i;
  logic [4:0]  rt_i, rd_i;

  logic        rw_o, m2r_o, br_o, mr_o, mw_o, zero_o, stall_o;
  logic [31:0] res_o, bt_o, rd2_o, hi_o, lo_o;
  logic [4:0]  wr_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  ex_stage #(.MUL_CYCLES(MULC)) dut (
    .clk(clk), .reset(reset),
    .ctrl_regWrite_id_ex(rw_i), .ctrl_memToReg_id_ex(m2r_i), .ctrl_branch_id_ex(br_i),
    .ctrl_memRead_id_ex(mr_i), .ctrl_memWrite_id_ex(mw_i), .ctrl_regDest_id_ex(rdst_i),
    .ctrl_aluSrc_id_ex(asrc_i), .ctrl_aluOp_id_ex(aluop_i),
    .supposed_next_address_id_ex(pc4_i), .read_data_1_id_ex(a_i), .read_data_2_id_ex(b_i),
    .extended_branch_offset_id_ex(ext_i),
    .next_instruction_20_16_id_ex(rt_i), .next_instruction_15_11_id_ex(rd_i),
    .ctrl_regWrite_ex_mem(rw_o), .ctrl_memToReg_ex_mem(m2r_o), .ctrl_branch_ex_mem(br_o),
    .ctrl_memRead_ex_mem(mr_o), .ctrl_memWrite_ex_mem(mw_o),
    .alu_result_ex_mem(res_o), .alu_zero_ex_mem(zero_o), .branch_target_ex_mem(bt_o),
    .read_data_2_ex_mem(rd2_o), .write_reg_ex_mem(wr_o),
    .hi(hi_o), .lo(lo_o), .stall_ex(stall_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                          input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] h, input logic [31:0] l);
    if (op == 2'b01) return x - y;
    if (op != 2'b10) return x + y;
    case (f)
      6'h20, 6'h21: return x + y;
      6'h22, 6'h23: return x - y;
      6'h24: return x & y;
      6'h25: return x | y;
      6'h26: return x ^ y;
      6'h27: return ~(x | y);
      6'h2A: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      6'h2B: return (x < y) ? 32'd1 : 32'd0;
      6'h10: return h;
      6'h12: return l;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xx, yy;
    xx = sgn ? {{32{x[31]}}, x} : {32'd0, x};
    yy = sgn ? {{32{y[31]}}, y} : {32'd0, y};
    return xx * yy;
  endfunction

  logic [31:0] ob;
  logic        cur_mul;
  logic [31:0] ref_res;
  assign ob      = asrc_i ? ext_i : b_i;
  assign cur_mul = (aluop_i == 2'b10) && ((ext_i[5:0] == 6'h18) || (ext_i[5:0] == 6'h19));

  logic [4:0]  m_ctrl;
  logic [31:0] m_res, m_bt, m_rd2, m_hi, m_lo;
  logic        m_zero, m_bub, m_done;
  logic [4:0]  m_wr;
  logic [63:0] m_pend;
  int          mul_left;

  assign ref_res = ref_alu(aluop_i, ext_i[5:0], a_i, ob, m_hi, m_lo);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ctrl <= '0; m_res <= '0; m_bt <= '0; m_rd2 <= '0; m_wr <= '0; m_zero <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_bub <= 1'b0; m_done <= 1'b0; m_pend <= '0; mul_left <= 0;
    end else if (mul_left != 0) begin
      m_bub <= 1'b1; m_ctrl <= '0;
      mul_left <= mul_left - 1;
      if (mul_left == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
        m_done <= 1'b1;
      end
    end else if (m_done) begin
      m_bub <= 1'b1; m_ctrl <= '0; m_done <= 1'b0;
    end else if (cur_mul) begin
      m_bub <= 1'b1; m_ctrl <= '0;
      m_pend <= ref_mul(ext_i[5:0] == 6'h18, a_i, ob);
      mul_left <= MULC;
    end else begin
      m_bub  <= 1'b0;
      m_ctrl <= {rw_i, m2r_i, br_i, mr_i, mw_i};
      m_res  <= ref_res;
      m_zero <= (ref_res == 32'd0);
      m_bt   <= pc4_i + (ext_i << 2);
      m_rd2  <= b_i;
      m_wr   <= rdst_i ? rd_i : rt_i;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_ex", {31'd0, stall_o},
          {31'd0, reset && ((mul_left != 0) || (!m_done && cur_mul))});
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
      chk("ctrl", {27'd0, rw_o, m2r_o, br_o, mr_o, mw_o}, {27'd0, m_ctrl});
      if (!m_bub) begin
        chk("alu_result", res_o, m_res);
        chk("alu_zero", {31'd0, zero_o}, {31'd0, m_zero});
        chk("branch_target", bt_o, m_bt);
        chk("read_data_2", rd2_o, m_rd2);
        chk("write_reg", {27'd0, wr_o}, {27'd0, m_wr});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_in(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ext,
                        input logic [31:0] pc, input logic [1:0] op, input logic [6:0] c,
                        input logic [4:0] rt, input logic [4:0] rd);
    a_i = a; b_i = b; ext_i = ext; pc4_i = pc; aluop_i = op;
    {rw_i, m2r_i, br_i, mr_i, mw_i, rdst_i, asrc_i} = c;
    rt_i = rt; rd_i = rd;
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the instruction
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ext,
                       input logic [31:0] pc, input logic [1:0] op, input logic [6:0] c,
                       input logic [4:0] rt, input logic [4:0] rd,
                       output int stalls, output logic rw_seen);
    logic st;
    logic ok;
    set_in(a, b, ext, pc, op, c, rt, rd);
    stalls = 0; rw_seen = 1'b0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      st = stall_o;
      if (i > 0 && rw_o) rw_seen = 1'b1;
      @(posedge clk);
      #1;
      if (!st) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL issue_timeout: stall_ex still high after 100 cycles");
    end
  endtask

  logic [5:0] fl [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                          6'h2A, 6'h2B, 6'h10, 6'h12, 6'h18, 6'h19, 6'h3F, 6'h00};

  initial begin
    int          ns;
    logic        rws;
    logic [31:0] ra, rb, re;
    logic [1:0]  rop;
    int          sel;

    set_in(32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 7'd0, 5'd0, 5'd0);
    #1 reset = 1'b0;
    #2;
    chk("reset_alu_result", res_o, 32'd0);
    chk("reset_ctrl", {27'd0, rw_o, m2r_o, br_o, mr_o, mw_o}, 32'd0);
    chk("reset_hi", hi_o, 32'd0);
    chk("reset_lo", lo_o, 32'd0);
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
    chk("reset_target", bt_o, 32'd0);
    chk_en = 1'b1;
    @(negedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;

    // R-type add with overflow wrap, rd selected
    issue(32'h7FFFFFFF, 32'd1, 32'h20, 32'd0, 2'b10, 7'b1000010, 5'd3, 5'd5, ns, rws);
    chk("add_result", res_o, 32'h80000000);
    chk("add_write_reg", {27'd0, wr_o}, 32'd5);
    chk("add_zero", {31'd0, zero_o}, 32'd0);
    // slt same operands: 0x7FFFFFFF < 1 is false
    issue(32'h7FFFFFFF, 32'd1, 32'h2A, 32'd0, 2'b10, 7'b1000010, 5'd3, 5'd5, ns, rws);
    chk("slt_result", res_o, 32'd0);
    // beq taken, negative offset
    issue(32'h1234, 32'h1234, 32'hFFFFFFFE, 32'h100, 2'b01, 7'b0010000, 5'd2, 5'd0, ns, rws);
    chk("beq_zero", {31'd0, zero_o}, 32'd1);
    chk("beq_target", bt_o, 32'h000000F8);
    chk("beq_branch", {31'd0, br_o}, 32'd1);
    // mult -3 * 7, regWrite requested but must never reach EX/MEM
    issue(32'hFFFFFFFD, 32'd7, 32'h18, 32'd0, 2'b10, 7'b1000010, 5'd0, 5'd0, ns, rws);
    chk("mult_stall_cycles", ns, 32'd33);
    chk("mult_regwrite_seen", {31'd0, rws}, 32'd0);
    chk("mult_done_regwrite", {31'd0, rw_o}, 32'd0);
    chk("mult_hi", hi_o, 32'hFFFFFFFF);
    chk("mult_lo", lo_o, 32'hFFFFFFEB);
    issue(32'd0, 32'd0, 32'h12, 32'd0, 2'b10, 7'b1000010, 5'd0, 5'd8, ns, rws);
    chk("mflo_result", res_o, 32'hFFFFFFEB);
    // multu max * max
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h19, 32'd0, 2'b10, 7'b1000010, 5'd0, 5'd0, ns, rws);
    chk("multu_stall_cycles", ns, 32'd33);
    chk("multu_hi", hi_o, 32'hFFFFFFFE);
    chk("multu_lo", lo_o, 32'h00000001);

    // Reset in the middle of a multiply (iteration 10)
    set_in(32'd5, 32'd9, 32'h18, 32'd0, 2'b10, 7'd0, 5'd0, 5'd0);
    repeat (11) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midreset_stall", {31'd0, stall_o}, 32'd0);
    chk("midreset_hi", hi_o, 32'd0);
    chk("midreset_lo", lo_o, 32'd0);
    chk("midreset_result", res_o, 32'd0);
    set_in(32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 7'd0, 5'd0, 5'd0);
    @(negedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    issue(32'd2, 32'd3, 32'h18, 32'd0, 2'b10, 7'd0, 5'd0, 5'd0, ns, rws);
    chk("post_reset_mult_stall", ns, 32'd33);
    chk("post_reset_mult_lo", lo_o, 32'd6);
    chk("post_reset_mult_hi", hi_o, 32'd0);

    // Random instruction stream
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      rop = (sel < 6) ? 2'b10 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b00 : 2'b11;
      re  = $urandom();
      if (rop == 2'b10) re[5:0] = fl[$urandom_range(0, 15)];
      ra  = $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom();
      issue(ra, rb, re, $urandom(), rop, 7'($urandom()), 5'($urandom()), 5'($urandom()), ns, rws);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that consumes the ID/EX pipeline bundle (control bits, operands, sign-extended immediate, next-PC, rt/rd fields).
- Performs ALU control decode, the ALU operation, branch-target computation and destination-register selection.
- Drives the registered EX/MEM bundle on posedge clk.
- Contains an iterative 32-cycle MULT/MULTU unit with HI/LO registers. It asserts stall_ex so the hazard logic holds upstream state while a multiply runs.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations. Must equal the operand width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- ctrl_regWrite_id_ex, ctrl_memToReg_id_ex, ctrl_branch_id_ex, ctrl_memRead_id_ex, ctrl_memWrite_id_ex, ctrl_regDest_id_ex, ctrl_aluSrc_id_ex  input  1 each  ID/EX control bits.
- ctrl_aluOp_id_ex  input  2  00 add, 01 sub, 10 R-type (funct decode), 11 add.
- supposed_next_address_id_ex  input  32  PC+4.
- read_data_1_id_ex, read_data_2_id_ex  input  32  rs/rt operands.
- extended_branch_offset_id_ex  input  32  sign-extended imm16; bits [5:0] are funct.
- next_instruction_20_16_id_ex, next_instruction_15_11_id_ex  input  5  rt, rd.
- ctrl_regWrite_ex_mem, ctrl_memToReg_ex_mem, ctrl_branch_ex_mem, ctrl_memRead_ex_mem, ctrl_memWrite_ex_mem  output  1 each  registered control bits.
- alu_result_ex_mem  output  32  registered ALU result.
- alu_zero_ex_mem  output  1  registered (ALU result == 0).
- branch_target_ex_mem  output  32  registered branch target.
- read_data_2_ex_mem  output  32  store data.
- write_reg_ex_mem  output  5  destination register.
- hi, lo  output  32 each  multiply result registers.
- stall_ex  output  1  combinational. Upstream stages and PC hold while this is 1.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0, including hi/lo.
  - FSM goes to IDLE; iteration counter 0.
  - Applies immediately, including mid-multiply. The partial product is discarded and hi/lo are cleared.
- Operand B = ctrl_aluSrc ? extended_branch_offset : read_data_2.
- ALU decode:
  - aluOp 00 and 11: A+B.
  - aluOp 01: A-B.
  - aluOp 10, by funct:
    - 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu (all 32-bit wrap, no overflow trap).
    - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
    - 0x2A slt (signed, result 0/1), 0x2B sltu.
    - 0x10 mfhi (result=hi), 0x12 mflo (result=lo).
    - 0x18 mult, 0x19 multu.
    - Any other funct: result 0.
- branch_target = supposed_next_address + (extended_branch_offset << 2), truncated to 32 bits.
- write_reg = ctrl_regDest ? rd : rt.
- Normal instruction: 1-cycle latency. At posedge clk, EX/MEM captures the control bits, result, zero flag, target, read_data_2 and write_reg.
- Bubble input (all control bits 0, aluOp 00) passes through as a bubble.
- Multiply FSM:
  - IDLE:
    - If aluOp=10 and funct is 0x18 or 0x19: stall_ex=1 combinationally.
    - At the edge, load |A| and |B| for signed, or raw values for multu. Latch the sign-fix flag (signed and sign(A)≠sign(B)). Clear the accumulator and counter. Go to MUL.
    - EX/MEM captures a bubble.
  - MUL:
    - stall_ex=1.
    - Each cycle: if multiplier LSB=1, add multiplicand into the upper accumulator half; shift the 64-bit accumulator right 1. Counter increments.
    - When counter = MUL_CYCLES-1, at that edge write hi/lo (two's-complement negate the 64-bit result if the sign-fix flag is set). Go to DONE.
    - EX/MEM captures a bubble every cycle.
  - DONE:
    - stall_ex=0.
    - EX/MEM captures a bubble: mult never writes a GPR, and ctrl_regWrite is forced 0.
    - Go to IDLE. The next instruction arrives in the following cycle.
- stall_ex is high for exactly 1+MUL_CYCLES = 33 consecutive cycles per multiply.
- Inputs change while in MUL: ignored. The operands were latched in IDLE; upstream is required to hold them.
- mfhi/mflo immediately after a multiply read the new hi/lo, because hi/lo are written before DONE.
- hi/lo change only on reset or multiply completion.

Test Plan:
- Reset: assert reset=0 mid-cycle -> all outputs 0 immediately, stall_ex=0. Release -> first instruction registered on the next posedge.
- R-type add, A=0x7FFFFFFF, B=1, regDest=1, rd=5 -> next edge: alu_result_ex_mem=0x80000000, write_reg_ex_mem=5, zero=0. Same operands with slt -> result 0.
- beq (aluOp 01, branch=1), A=B=0x1234, PC+4=0x100, offset=0xFFFFFFFE -> zero=1, branch_target=0x000000F8.
- mult A=0xFFFFFFFD (-3), B=7 -> stall_ex high 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; EX/MEM regWrite 0 throughout. Following mflo -> alu_result=0xFFFFFFEB.
- multu A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 33 stall cycles.
- Assert reset at MUL iteration 10 -> stall_ex=0, hi=lo=0. After release, FSM is in IDLE, and a new mult 2*3 gives lo=6.
